// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_ctrl_pkg
//  Description : Shared mode encodings and prescaler sizing helpers for the
//                multi-channel LED blink controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_ctrl_pkg;

  // Channel operating modes as carried on cfg_mode
  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

  // Clocks per prescaler tick
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Width of a counter that spans 0..div-1
  function automatic int div_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_blink_ctrl_chan.sv
`default_nettype none
// ============================================================================
//  Module      : led_chan
//  Description : One LED channel: mode / half-period / tick counter registers
//                plus the led and done outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_chan
  import led_ctrl_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int DEF_HALF = 500
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                we,
  input  logic [1:0]          wr_mode,
  input  logic [PERIOD_W-1:0] wr_half,
  output logic                led,
  output logic                done
);

  logic [1:0]          mode;
  logic [PERIOD_W-1:0] half;
  logic [PERIOD_W-1:0] cnt;
  logic                at_end;

  // half is never zero, so half-1 cannot underflow and cnt stays below half
  assign at_end = (cnt == (half - PERIOD_W'(1)));

  // Channel state: a write always beats a coincident tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode <= MODE_BLINK;
      half <= PERIOD_W'(DEF_HALF);
      cnt  <= '0;
      led  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (we) begin
        mode <= wr_mode;
        half <= (wr_half == '0) ? PERIOD_W'(1) : wr_half;
        cnt  <= '0;
        led  <= (wr_mode != MODE_OFF);
      end else if (tick) begin
        if ((mode == MODE_BLINK) || (mode == MODE_ONESHOT)) begin
          if (at_end) begin
            cnt <= '0;
            if (mode == MODE_BLINK) begin
              led <= ~led;
            end else begin
              led  <= 1'b0;
              mode <= MODE_OFF;
              done <= 1'b1;
            end
          end else begin
            cnt <= cnt + PERIOD_W'(1);
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_blink_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_blink_ctrl
//  Description : Multi-channel LED driver with a shared 1 ms prescaler and a
//                one-channel-per-cycle configuration port.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_blink_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 1_000,
  parameter int N_CH        = 2,
  parameter int PERIOD_W    = 16,
  parameter int DEF_HALF    = 500
) (
  input  logic                sys_clk_50M,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_half,
  output logic [N_CH-1:0]     led,
  output logic [N_CH-1:0]     done,
  output logic                tick_o
);

  localparam int DIV   = calc_div(CLK_FREQ_HZ, TICK_HZ);
  localparam int DIV_W = div_width(DIV);

  if (DIV < 2) begin : g_bad_div
    $error("led_blink_ctrl: CLK_FREQ_HZ/TICK_HZ must be at least 2");
  end

  logic [DIV_W-1:0] presc;

  // Prescaler: tick_o is high the cycle after the count reaches DIV-1
  always_ff @(posedge sys_clk_50M) begin
    if (!rst_n) begin
      presc  <= '0;
      tick_o <= 1'b0;
    end else begin
      tick_o <= (presc == DIV_W'(DIV - 1));
      presc  <= (presc == DIV_W'(DIV - 1)) ? '0 : presc + DIV_W'(1);
    end
  end

  // Channel index match implies cfg_ch < N_CH, so out-of-range writes are dropped
  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    logic ch_we;
    assign ch_we = cfg_we && (cfg_ch == 4'(i));

    led_chan #(
      .PERIOD_W (PERIOD_W),
      .DEF_HALF (DEF_HALF)
    ) u_chan (
      .clk     (sys_clk_50M),
      .rst_n   (rst_n),
      .tick    (tick_o),
      .we      (ch_we),
      .wr_mode (cfg_mode),
      .wr_half (cfg_half),
      .led     (led[i]),
      .done    (done[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_led_blink_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_blink_ctrl
//  Description : Self-checking bench for led_blink_ctrl with a behavioural
//                reference model and an expected-response queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_blink_ctrl;

  localparam int CLK_FREQ_HZ = 10_000;
  localparam int TICK_HZ     = 1_000;
  localparam int DIV         = CLK_FREQ_HZ / TICK_HZ;
  localparam int N_CH        = 2;
  localparam int PERIOD_W    = 16;
  localparam int DEF_HALF    = 500;

  typedef struct packed {
    logic [N_CH-1:0] led;
    logic [N_CH-1:0] done;
    logic            tick;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_we = 1'b0;
  logic [3:0]          cfg_ch = '0;
  logic [1:0]          cfg_mode = '0;
  logic [PERIOD_W-1:0] cfg_half = '0;
  logic [N_CH-1:0]     led;
  logic [N_CH-1:0]     done;
  logic                tick_o;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model state: ticks counted since the last write per channel
  int   m_cyc;
  bit   m_tick;
  int   m_mode[N_CH];
  int   m_half[N_CH];
  int   m_n[N_CH];
  bit   m_start[N_CH];
  bit   m_led[N_CH];
  bit   m_done[N_CH];

  always #5 clk = ~clk;

  led_blink_ctrl #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .TICK_HZ     (TICK_HZ),
    .N_CH        (N_CH),
    .PERIOD_W    (PERIOD_W),
    .DEF_HALF    (DEF_HALF)
  ) dut (
    .sys_clk_50M (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_mode    (cfg_mode),
    .cfg_half    (cfg_half),
    .led         (led),
    .done        (done),
    .tick_o      (tick_o)
  );

  // Advance the model by one clock edge given the inputs presented to it
  task automatic model(input bit r, input bit we, input int ch, input int md, input int hf);
    bit tick_prev;
    tick_prev = m_tick;
    if (!r) begin
      m_cyc  = 0;
      m_tick = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        m_mode[i] = 2; m_half[i] = DEF_HALF; m_n[i] = 0;
        m_start[i] = 1'b0; m_led[i] = 1'b0; m_done[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        m_done[i] = 1'b0;
        if (we && ch == i) begin
          m_mode[i]  = md;
          m_half[i]  = (hf == 0) ? 1 : hf;
          m_n[i]     = 0;
          m_start[i] = (md != 0);
          m_led[i]   = m_start[i];
        end else if (tick_prev && (m_mode[i] == 2 || m_mode[i] == 3)) begin
          m_n[i]++;
          if (m_mode[i] == 2) begin
            m_led[i] = m_start[i] ^ bit'((m_n[i] / m_half[i]) % 2);
          end else if (m_n[i] == m_half[i]) begin
            m_led[i]  = 1'b0;
            m_mode[i] = 0;
            m_done[i] = 1'b1;
          end
        end
      end
      m_cyc++;
      m_tick = ((m_cyc % DIV) == 0);
    end
  endtask

  // Drive one cycle of stimulus and queue the response expected after the edge
  task automatic step(input bit r, input bit we, input int ch, input int md, input int hf);
    exp_t e;
    @(negedge clk);
    rst_n    = r;
    cfg_we   = we;
    cfg_ch   = 4'(ch);
    cfg_mode = 2'(md);
    cfg_half = PERIOD_W'(hf);
    model(r, we, ch, md, hf);
    for (int i = 0; i < N_CH; i++) begin
      e.led[i]  = m_led[i];
      e.done[i] = m_done[i];
    end
    e.tick = m_tick;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0);
  endtask

  // Monitor: compare every registered output shortly after each edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks += 3;
      if (led !== e.led) begin
        errors++;
        $display("FAIL led t=%0t got=%b exp=%b", $time, led, e.led);
      end
      if (done !== e.done) begin
        errors++;
        $display("FAIL done t=%0t got=%b exp=%b", $time, done, e.done);
      end
      if (tick_o !== e.tick) begin
        errors++;
        $display("FAIL tick_o t=%0t got=%b exp=%b", $time, tick_o, e.tick);
      end
    end
  end

  initial begin
    int guard;
    // Reset for 3 cycles, then default BLINK at 500 ticks past tick 1000
    repeat (3) step(0, 0, 0, 0, 0);
    idle(10_050);
    // ch1 BLINK half=3
    step(1, 1, 1, 2, 3);
    idle(130);
    // ch0 ONESHOT half=2
    step(1, 1, 0, 3, 2);
    idle(40);
    // ch0 ON, OFF, BLINK with half=0
    step(1, 1, 0, 1, 7);
    idle(500);
    step(1, 1, 0, 0, 4);
    idle(30);
    step(1, 1, 0, 2, 0);
    idle(40);
    // Out-of-range channel is ignored
    step(1, 1, 5, 1, 2);
    idle(20);
    // Write coincident with a tick on ch1
    guard = 0;
    while (!m_tick && guard < 2 * DIV) begin
      idle(1);
      guard++;
    end
    step(1, 1, 1, 3, 3);
    idle(50);
    // Re-arm ONESHOT while active restarts it without a done pulse
    step(1, 1, 0, 3, 4);
    idle(25);
    step(1, 1, 0, 3, 4);
    idle(60);
    // Randomized writes across valid and invalid channels
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 29) == 0)
        step(1, 1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
      else
        idle(1);
    end
    // Reset in the middle of a ONESHOT
    step(1, 1, 0, 3, 5);
    idle(15);
    step(0, 0, 0, 0, 0);
    idle(30);
    // Let the monitor drain the queue
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
